osci_capture_ctrl: RTL

OSCI_CAPTURE_CTRL -- requirements
Module: osci_capture_ctrl

---
 rtl/osci_capture_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/osci_capture_ctrl.sv
// Oscilloscope capture controller.
// Streams ADC samples into a capture buffer while armed, detects a level
// crossing on the selected edge, records where the trigger sample landed,
// stores a programmed number of post-trigger samples and raises done_irq.
// Optional pre-trigger fill phase: define OSCI_CAPTURE_PRETRIG_EN.
module osci_capture_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  input  logic [DATA_WIDTH-1:0] cfg_trig_level,
  input  logic                  cfg_trig_edge,
  input  logic [ADDR_WIDTH-1:0] cfg_post_count,
  input  logic [ADDR_WIDTH-1:0] cfg_pre_count,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  buf_we,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0] buf_data,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  done_irq,
  input  logic                  irq_ack
);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef OSCI_CAPTURE_PRETRIG_EN
    ST_PRE,
`endif
    ST_ARMED,
    ST_POST,
    ST_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] level_reg, level_next;
  logic                  edge_reg, edge_next;
  logic [ADDR_WIDTH-1:0] post_reg, post_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] prev_sample_reg, prev_sample_next;
  logic                  prev_valid_reg, prev_valid_next;
  logic [ADDR_WIDTH-1:0] trig_addr_reg, trig_addr_next;
  logic                  buf_we_reg, buf_we_next;
  logic [ADDR_WIDTH-1:0] buf_addr_reg, buf_addr_next;
  logic [DATA_WIDTH-1:0] buf_data_reg, buf_data_next;
  logic                  done_irq_reg, done_irq_next;
  // one-cycle delay so done_irq rises the cycle after the final write
  logic                  finish_reg, finish_next;

  logic                  busy_w;
  logic                  take;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] cnt_inc;

`ifdef OSCI_CAPTURE_PRETRIG_EN
  logic [ADDR_WIDTH-1:0] pre_reg, pre_next;
  assign busy_w = (state_reg == ST_PRE) || (state_reg == ST_ARMED) || (state_reg == ST_POST);
`else
  // pre-trigger count has no meaning without the PRE phase
  logic unused_pre;
  assign unused_pre = ^cfg_pre_count;
  assign busy_w = (state_reg == ST_ARMED) || (state_reg == ST_POST);
`endif

  assign take    = sample_valid && busy_w;
  assign cnt_inc = cnt_reg + ONE_A;
  // level crossing between the previous armed sample and the current one
  assign hit = edge_reg ? ((prev_sample_reg >= level_reg) && (sample_data <  level_reg))
                        : ((prev_sample_reg <  level_reg) && (sample_data >= level_reg));

  // next-state, write-port and interrupt logic
  always_comb begin
    state_next       = state_reg;
    level_next       = level_reg;
    edge_next        = edge_reg;
    post_next        = post_reg;
`ifdef OSCI_CAPTURE_PRETRIG_EN
    pre_next         = pre_reg;
`endif
    addr_next        = addr_reg;
    cnt_next         = cnt_reg;
    prev_sample_next = prev_sample_reg;
    prev_valid_next  = prev_valid_reg;
    trig_addr_next   = trig_addr_reg;
    buf_we_next      = 1'b0;
    buf_addr_next    = buf_addr_reg;
    buf_data_next    = buf_data_reg;
    finish_next      = 1'b0;
    done_irq_next    = done_irq_reg;

    // a completion landing together with an ack keeps the interrupt set
    if (irq_ack)    done_irq_next = 1'b0;
    if (finish_reg) done_irq_next = 1'b1;

    if (take) begin
      buf_we_next      = 1'b1;
      buf_addr_next    = addr_reg;
      buf_data_next    = sample_data;
      addr_next        = addr_reg + ONE_A;
      prev_sample_next = sample_data;
    end

    case (state_reg)
`ifdef OSCI_CAPTURE_PRETRIG_EN
      ST_PRE: begin
        if (sample_valid) begin
          if (cnt_inc == pre_reg) begin
            state_next      = ST_ARMED;
            cnt_next        = '0;
            prev_valid_next = 1'b0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
`endif
      ST_ARMED: begin
        if (sample_valid) begin
          prev_valid_next = 1'b1;
          if (prev_valid_reg && hit) begin
            trig_addr_next = addr_reg;
            cnt_next       = '0;
            if (post_reg == '0) begin
              state_next  = ST_DONE;
              finish_next = 1'b1;
            end else begin
              state_next = ST_POST;
            end
          end
        end
      end
      ST_POST: begin
        if (sample_valid) begin
          if (cnt_inc == post_reg) begin
            state_next  = ST_DONE;
            finish_next = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      default: ;
    endcase

    if (cfg_abort) begin
      state_next  = ST_IDLE;
      buf_we_next = 1'b0;
      finish_next = 1'b0;
    end else if (cfg_arm && ((state_reg == ST_IDLE) || (state_reg == ST_DONE))) begin
      level_next      = cfg_trig_level;
      edge_next       = cfg_trig_edge;
      post_next       = cfg_post_count;
      addr_next       = '0;
      cnt_next        = '0;
      prev_valid_next = 1'b0;
      done_irq_next   = 1'b0;
      finish_next     = 1'b0;
      state_next      = ST_ARMED;
`ifdef OSCI_CAPTURE_PRETRIG_EN
      pre_next = cfg_pre_count;
      if (cfg_pre_count != '0) state_next = ST_PRE;
`endif
    end
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_reg       <= ST_IDLE;
      level_reg       <= '0;
      edge_reg        <= 1'b0;
      post_reg        <= '0;
`ifdef OSCI_CAPTURE_PRETRIG_EN
      pre_reg         <= '0;
`endif
      addr_reg        <= '0;
      cnt_reg         <= '0;
      prev_sample_reg <= '0;
      prev_valid_reg  <= 1'b0;
      trig_addr_reg   <= '0;
      buf_we_reg      <= 1'b0;
      buf_addr_reg    <= '0;
      buf_data_reg    <= '0;
      done_irq_reg    <= 1'b0;
      finish_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      level_reg       <= level_next;
      edge_reg        <= edge_next;
      post_reg        <= post_next;
`ifdef OSCI_CAPTURE_PRETRIG_EN
      pre_reg         <= pre_next;
`endif
      addr_reg        <= addr_next;
      cnt_reg         <= cnt_next;
      prev_sample_reg <= prev_sample_next;
      prev_valid_reg  <= prev_valid_next;
      trig_addr_reg   <= trig_addr_next;
      buf_we_reg      <= buf_we_next;
      buf_addr_reg    <= buf_addr_next;
      buf_data_reg    <= buf_data_next;
      done_irq_reg    <= done_irq_next;
      finish_reg      <= finish_next;
    end
  end

  assign buf_we    = buf_we_reg;
  assign buf_addr  = buf_addr_reg;
  assign buf_data  = buf_data_reg;
  assign trig_addr = trig_addr_reg;
  assign busy      = busy_w;
  assign done_irq  = done_irq_reg;

endmodule
